// File: rtl/alu_exec_ctrl_pkg.sv
// Shared definitions for the execute-stage controller: ALU opcode
// encodings, controller state encodings and the legal-opcode check.
package alu_exec_ctrl_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_EQ  = 4'd7;
  localparam logic [3:0] OP_NEQ = 4'd8;
  localparam logic [3:0] OP_LT  = 4'd9;
  localparam logic [3:0] OP_LTE = 4'd10;
  localparam logic [3:0] OP_GT  = 4'd11;
  localparam logic [3:0] OP_GTE = 4'd12;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Listed explicitly so a future opcode added to the ALU does not
  // silently become legal here.
  function automatic logic op_legal(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_NOT,
                      OP_EQ, OP_NEQ, OP_LT, OP_LTE, OP_GT, OP_GTE};
  endfunction

endpackage

// File: rtl/alu_exec_ctrl_regfile.sv
// General register file: two async operand read ports, an async debug
// read port and two write ports. Port 0 (writeback) wins an address tie.
module alu_regfile
  import alu_exec_ctrl_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int AW    = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [AW-1:0] raddr0_i,
  output logic [31:0]   rdata0_o,
  input  logic [AW-1:0] raddr1_i,
  output logic [31:0]   rdata1_o,
  input  logic [AW-1:0] dbg_addr_i,
  output logic [31:0]   dbg_data_o,
  input  logic          we0_i,
  input  logic [AW-1:0] waddr0_i,
  input  logic [31:0]   wdata0_i,
  input  logic          we1_i,
  input  logic [AW-1:0] waddr1_i,
  input  logic [31:0]   wdata1_i
);

  logic [31:0] mem_q [NREGS];

  assign rdata0_o   = mem_q[raddr0_i];
  assign rdata1_o   = mem_q[raddr1_i];
  assign dbg_data_o = mem_q[dbg_addr_i];

  // Per-entry write with port 0 taking priority on a same-address collision
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (we0_i && (waddr0_i == AW'(i)))      mem_q[i] <= wdata0_i;
        else if (we1_i && (waddr1_i == AW'(i))) mem_q[i] <= wdata1_i;
      end
    end
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller in front of the combinational ALU.
//   state   | meaning
//   IDLE    | ready for a command; operands loaded from regfile on accept
//   EXEC    | ALU settling on registered operands; result captured at edge
//   RESP    | response held until consumed; first cycle writes back
module alu_exec_ctrl
  import alu_exec_ctrl_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int AW    = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [3:0]    cmd_op_i,
  input  logic [AW-1:0] cmd_rd_i,
  input  logic [AW-1:0] cmd_rs1_i,
  input  logic [AW-1:0] cmd_rs2_i,
  input  logic          ld_en_i,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [31:0]   ld_data_i,
  input  logic [AW-1:0] dbg_addr_i,
  output logic [31:0]   dbg_data_o,
  output logic [31:0]   alu_a_o,
  output logic [31:0]   alu_b_o,
  output logic [3:0]    alu_sel_o,
  input  logic [31:0]   alu_out_i,
  input  logic          alu_over_i,
  input  logic          alu_under_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [31:0]   rsp_data_o,
  output logic          rsp_over_o,
  output logic          rsp_under_o,
  output logic          rsp_illegal_o,
  output logic          sticky_over_o,
  output logic          sticky_under_o,
  input  logic          clr_sticky_i
);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] rd_q;
  logic [31:0]   alu_a_q, alu_b_q;
  logic [3:0]    alu_sel_q;
  logic [31:0]   rsp_data_q;
  logic          rsp_over_q, rsp_under_q, rsp_illegal_q;
  logic          wb_pending_q;
  logic          sticky_over_q, sticky_under_q;
  logic [31:0]   rs1_data, rs2_data;
  logic          wb_en, exec_illegal;

  assign cmd_ready_o    = (state_q == ST_IDLE);
  assign rsp_valid_o    = (state_q == ST_RESP);
  assign alu_a_o        = alu_a_q;
  assign alu_b_o        = alu_b_q;
  assign alu_sel_o      = alu_sel_q;
  assign rsp_data_o     = rsp_data_q;
  assign rsp_over_o     = rsp_over_q;
  assign rsp_under_o    = rsp_under_q;
  assign rsp_illegal_o  = rsp_illegal_q;
  assign sticky_over_o  = sticky_over_q;
  assign sticky_under_o = sticky_under_q;

  // wb_pending_q is high only in the first RESP cycle, so writeback happens once
  assign wb_en        = wb_pending_q & ~rsp_illegal_q;
  assign exec_illegal = ~op_legal(alu_sel_q);

  alu_regfile #(.NREGS(NREGS), .AW(AW)) u_regfile (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .raddr0_i   (cmd_rs1_i),
    .rdata0_o   (rs1_data),
    .raddr1_i   (cmd_rs2_i),
    .rdata1_o   (rs2_data),
    .dbg_addr_i (dbg_addr_i),
    .dbg_data_o (dbg_data_o),
    .we0_i      (wb_en),
    .waddr0_i   (rd_q),
    .wdata0_i   (rsp_data_q),
    .we1_i      (ld_en_i),
    .waddr1_i   (ld_addr_i),
    .wdata1_i   (ld_data_i)
  );

  // Next-state logic: one operation in flight at a time
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cmd_valid_i) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, operand launch and result capture
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      rd_q          <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_sel_q     <= '0;
      rsp_data_q    <= '0;
      rsp_over_q    <= 1'b0;
      rsp_under_q   <= 1'b0;
      rsp_illegal_q <= 1'b0;
      wb_pending_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wb_pending_q <= 1'b0;
      if (state_q == ST_IDLE && cmd_valid_i) begin
        rd_q      <= cmd_rd_i;
        alu_a_q   <= rs1_data;
        alu_b_q   <= rs2_data;
        alu_sel_q <= cmd_op_i;
      end
      if (state_q == ST_EXEC) begin
        wb_pending_q  <= 1'b1;
        rsp_illegal_q <= exec_illegal;
        rsp_data_q    <= exec_illegal ? '0 : alu_out_i;
        rsp_over_q    <= alu_over_i & ~exec_illegal;
        rsp_under_q   <= alu_under_i & ~exec_illegal;
      end
    end
  end

  // Sticky flags: a set in the RESP entry cycle overrides a concurrent clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sticky_over_q  <= 1'b0;
      sticky_under_q <= 1'b0;
    end else begin
      sticky_over_q  <= (sticky_over_q & ~clr_sticky_i) | (wb_pending_q & rsp_over_q);
      sticky_under_q <= (sticky_under_q & ~clr_sticky_i) | (wb_pending_q & rsp_under_q);
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
module tb_alu_exec_ctrl;

  typedef struct packed {
    logic [31:0] data;
    logic        over;
    logic        under;
    logic        illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [2:0]  cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
  logic        ld_en = 1'b0;
  logic [2:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [2:0]  dbg_addr = '0;
  logic [31:0] dbg_data;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_sel;
  logic        alu_over, alu_under;
  logic        rsp_valid, rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_over, rsp_under, rsp_illegal;
  logic        sticky_over, sticky_under;
  logic        clr_sticky = 1'b0;

  int checks = 0;
  int failures = 0;

  // reference state
  logic [31:0] mregs [8];
  logic        m_so = 1'b0, m_su = 1'b0;
  exp_t        exp_q [$];
  exp_t        pend, e_new;
  logic [2:0]  pend_rd;
  int          wb_cnt = 0;
  logic        hs, so_set, su_set;

  logic        ready_hold = 1'b0, ready_rand = 1'b0, dbg_rand = 1'b0;
  logic [3:0]  op;
  exp_t        stub_r;

  alu_exec_ctrl #(.NREGS(8), .AW(3)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_rd_i(cmd_rd), .cmd_rs1_i(cmd_rs1), .cmd_rs2_i(cmd_rs2),
    .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
    .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_sel_o(alu_sel),
    .alu_out_i(alu_out), .alu_over_i(alu_over), .alu_under_i(alu_under),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_over_o(rsp_over), .rsp_under_o(rsp_under), .rsp_illegal_o(rsp_illegal),
    .sticky_over_o(sticky_over), .sticky_under_o(sticky_under),
    .clr_sticky_i(clr_sticky)
  );

  always #5 clk = ~clk;

  // Behavioural 32-bit ALU: signed arithmetic with range-based over/under.
  // Undefined opcodes produce junk with both flags set.
  function automatic exp_t ref_alu(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    longint sa, sb, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0;
    res = 0;
    case (o)
      4'd0, 4'd1, 4'd2: begin
        res = (o == 4'd0) ? sa + sb : (o == 4'd1) ? sa - sb : sa * sb;
        r.data  = res[31:0];
        r.over  = res > 64'sd2147483647;
        r.under = res < -64'sd2147483648;
      end
      4'd3:  r.data = a & b;
      4'd4:  r.data = a | b;
      4'd5:  r.data = a ^ b;
      4'd6:  r.data = ~a;
      4'd7:  r.data = {31'd0, sa == sb};
      4'd8:  r.data = {31'd0, sa != sb};
      4'd9:  r.data = {31'd0, sa < sb};
      4'd10: r.data = {31'd0, sa <= sb};
      4'd11: r.data = {31'd0, sa > sb};
      4'd12: r.data = {31'd0, sa >= sb};
      default: begin
        r.data = a ^ b ^ 32'h5A5A_5A5A;
        r.over = 1'b1;
        r.under = 1'b1;
        r.illegal = 1'b1;
      end
    endcase
    return r;
  endfunction

  always_comb begin
    stub_r    = ref_alu(alu_sel, alu_a, alu_b);
    alu_out   = stub_r.data;
    alu_over  = stub_r.over;
    alu_under = stub_r.under;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Reference model: operands read before this edge's writes; the
  // writeback lands two edges after accept and beats an external load.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mregs[i] = '0;
      exp_q.delete();
      wb_cnt = 0;
      m_so = 1'b0;
      m_su = 1'b0;
    end else begin
      hs = cmd_valid && cmd_ready;
      so_set = 1'b0;
      su_set = 1'b0;
      if (hs) begin
        e_new = ref_alu(cmd_op, mregs[cmd_rs1], mregs[cmd_rs2]);
        if (e_new.illegal) e_new = '{32'h0, 1'b0, 1'b0, 1'b1};
        exp_q.push_back(e_new);
      end
      if (ld_en) mregs[ld_addr] = ld_data;
      if (wb_cnt > 0) begin
        wb_cnt--;
        if (wb_cnt == 0) begin
          if (!pend.illegal) mregs[pend_rd] = pend.data;
          so_set = pend.over;
          su_set = pend.under;
        end
      end
      if (hs) begin
        pend = e_new;
        pend_rd = cmd_rd;
        wb_cnt = 2;
      end
      m_so = (m_so && !clr_sticky) || so_set;
      m_su = (m_su && !clr_sticky) || su_set;
    end
  end

  // Monitor: every presented response must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          fail_now("rsp_without_cmd");
        end else begin
          chk("rsp_data", rsp_data, exp_q[0].data);
          chkb("rsp_over", rsp_over, exp_q[0].over);
          chkb("rsp_under", rsp_under, exp_q[0].under);
          chkb("rsp_illegal", rsp_illegal, exp_q[0].illegal);
          chkb("cmd_ready_in_resp", cmd_ready, 1'b0);
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
      chk("dbg_data", dbg_data, mregs[dbg_addr]);
      chkb("sticky_over", sticky_over, m_so);
      chkb("sticky_under", sticky_under, m_su);
    end
  end

  always @(posedge clk) begin
    #1;
    rsp_ready = !ready_hold && (!ready_rand || ($urandom_range(0, 3) != 0));
    if (dbg_rand) dbg_addr = 3'($urandom_range(0, 7));
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic load(input logic [2:0] a, input logic [31:0] d);
    ld_en = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // Returns #1 after the accepting edge (the EXEC cycle)
  task automatic issue(input logic [3:0] o, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_op = o;
    cmd_rd = rd;
    cmd_rs1 = rs1;
    cmd_rs2 = rs2;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 50);
    if (n >= 50) fail_now("cmd_accept");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while (!(exp_q.size() == 0 && cmd_ready) && n < 100);
    if (n >= 100) fail_now("wait_idle");
    @(posedge clk); #1;
  endtask

  task automatic dbg_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    chk(name, dbg_data, exp);
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chkb("reset_cmd_ready", cmd_ready, 1'b1);
    chkb("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_alu_a", alu_a, 32'h0);
    chk("reset_alu_b", alu_b, 32'h0);
    chk("reset_alu_sel", {28'd0, alu_sel}, 32'h0);
    chk("reset_rsp_data", rsp_data, 32'h0);
    chkb("reset_flags", rsp_over | rsp_under | rsp_illegal | sticky_over | sticky_under, 1'b0);
    for (int i = 0; i < 8; i++) dbg_chk("reset_reg", 3'(i), 32'h0);
    @(posedge clk); #1;

    // ADD overflow with latency check
    load(3'd1, 32'h7FFF_FFFF);
    load(3'd2, 32'h0000_0001);
    issue(4'd0, 3'd3, 3'd1, 3'd2);
    @(negedge clk);
    chkb("latency_exec", rsp_valid, 1'b0);
    @(negedge clk);
    chkb("latency_resp", rsp_valid, 1'b1);
    chk("add_data", rsp_data, 32'h8000_0000);
    chkb("add_over", rsp_over, 1'b1);
    wait_idle();
    chkb("add_sticky_over", sticky_over, 1'b1);
    dbg_chk("add_r3", 3'd3, 32'h8000_0000);

    // SUB underflow, then clear sticky
    load(3'd1, 32'h8000_0000);
    load(3'd2, 32'h0000_0001);
    issue(4'd1, 3'd4, 3'd1, 3'd2);
    wait_idle();
    chkb("sub_sticky_under", sticky_under, 1'b1);
    dbg_chk("sub_r4", 3'd4, 32'h7FFF_FFFF);
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    @(negedge clk);
    chkb("clr_sticky_over", sticky_over, 1'b0);
    chkb("clr_sticky_under", sticky_under, 1'b0);
    @(posedge clk); #1;

    // MUL with backpressure
    load(3'd5, 32'hFFFF_FFFE);
    load(3'd6, 32'h0000_0003);
    ready_hold = 1'b1;
    issue(4'd2, 3'd5, 3'd5, 3'd6);
    repeat (7) begin
      @(negedge clk);
      chkb("hold_cmd_ready", cmd_ready, 1'b0);
    end
    chk("hold_rsp_data", rsp_data, 32'hFFFF_FFFA);
    ready_hold = 1'b0;
    wait_idle();
    dbg_chk("mul_r5", 3'd5, 32'hFFFF_FFFA);

    // LT with a same-address load in the RESP entry cycle
    issue(4'd9, 3'd7, 3'd5, 3'd6);
    @(posedge clk); #1;
    ld_en = 1'b1; ld_addr = 3'd7; ld_data = 32'h0000_DEAD;
    @(posedge clk); #1;
    ld_en = 1'b0;
    wait_idle();
    dbg_chk("collide_r7", 3'd7, 32'h0000_0001);

    // LT again with a different-address load in the RESP entry cycle
    issue(4'd9, 3'd7, 3'd5, 3'd6);
    @(posedge clk); #1;
    ld_en = 1'b1; ld_addr = 3'd2; ld_data = 32'h0000_1234;
    @(posedge clk); #1;
    ld_en = 1'b0;
    wait_idle();
    dbg_chk("dual_r2", 3'd2, 32'h0000_1234);
    dbg_chk("dual_r7", 3'd7, 32'h0000_0001);

    // Illegal opcode must not write back
    issue(4'd14, 3'd1, 3'd5, 3'd6);
    @(negedge clk);
    @(negedge clk);
    chkb("illegal_flag", rsp_illegal, 1'b1);
    chk("illegal_data", rsp_data, 32'h0);
    wait_idle();
    dbg_chk("illegal_r1", 3'd1, 32'h8000_0000);

    // Reset while in EXEC
    issue(4'd0, 3'd0, 3'd1, 3'd2);
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chkb("rst_rsp_valid", rsp_valid, 1'b0);
    end
    for (int i = 0; i < 8; i++) dbg_chk("rst_reg_zero", 3'(i), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chkb("post_rst_cmd_ready", cmd_ready, 1'b1);
      chkb("post_rst_rsp_valid", rsp_valid, 1'b0);
    end
    @(posedge clk); #1;

    // Randomized traffic
    ready_rand = 1'b1;
    dbg_rand = 1'b1;
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 2) == 0) load(3'($urandom_range(0, 7)), rand_val());
      op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(13, 15)) : 4'($urandom_range(0, 12));
      ld_en = ($urandom_range(0, 3) == 0);
      ld_addr = 3'($urandom_range(0, 7));
      ld_data = rand_val();
      clr_sticky = ($urandom_range(0, 5) == 0);
      issue(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      ld_en = 1'b0;
      clr_sticky = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
        ld_en = 1'b1;
        ld_addr = 3'($urandom_range(0, 7));
        ld_data = rand_val();
        clr_sticky = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        ld_en = 1'b0;
        clr_sticky = 1'b0;
      end
      wait_idle();
    end
    ready_rand = 1'b0;
    dbg_rand = 1'b0;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
